// File: rtl/ibex_irq_arbiter.sv
// ibex_irq_arbiter: interrupt front-end for the core controller.
// Synchronises external IRQ lines and latches them into a pending register.
// It picks the lowest-index eligible source and holds a stable req/id pair
// until the controller acks it. It also drives the raw wake-up level irq_o.
// Optional build macro IBEX_IRQ_MASK_EN adds an irq_mask_i port. Without the
// macro, every source is always eligible.
module ibex_irq_arbiter #(
  parameter int unsigned NUM_IRQ     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_MASK   = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic               m_ie_i,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i,
`ifdef IBEX_IRQ_MASK_EN
  input  logic [NUM_IRQ-1:0] irq_mask_i,
`endif
  output logic               irq_req_ctrl_o,
  output logic [4:0]         irq_id_ctrl_o,
  output logic               irq_o,
  output logic [NUM_IRQ-1:0] irq_pending_o
);

  typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_e;

  localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] set_event, clr_vec, mask, eligible;
  logic [4:0]         win_id;
  logic [4:0]         id_q, id_d;
  logic [4:0]         ack_id_q, ack_id_d;
  state_e             state_q, state_d;

`ifdef IBEX_IRQ_MASK_EN
  assign mask = irq_mask_i;
`else
  assign mask = '1;
`endif

  // Input synchronisers plus one flop of edge history on the synchronised level.
  // NOTE: the synchroniser chain is an array of flops, not a RAM. It is reset so
  // that no stale line level reaches the pending register after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so each stage
      // reads the value its predecessor held before this clock edge.
      sync_q[0] <= irq_lines_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Set events: edge lines on a synchronised 0->1 transition, level lines while high.
  // The pending bit for the acked id is cleared in CLEAR. A simultaneous set event
  // on the same bit wins. Ids at or above NUM_IRQ match no bit and clear nothing.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    clr_vec   = '0;
    set_event = (EDGE_SEL & sync_q[SYNC_STAGES-1] & ~prev_q)
              | (~EDGE_SEL & sync_q[SYNC_STAGES-1]);
    for (int i = 0; i < int'(NUM_IRQ); i++)
      clr_vec[i] = (state_q == CLEAR) && (ack_id_q == 5'(i));
    pending_d = (pending_q & ~clr_vec) | set_event;
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Fixed-priority pick: the lowest eligible index wins.
  always_comb begin
    eligible = pending_q & mask;
    win_id   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--)
      if (eligible[i]) win_id = 5'(i);
  end

  // Request FSM: next state, the latched request id and the latched ack id.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ack_id_d = ack_id_q;
    unique case (state_q)
      IDLE: begin
        if (m_ie_i && |eligible) begin
          state_d = REQ;
          id_d    = win_id;
        end
      end
      REQ: begin
        // The id stays frozen here. A newly pending higher-priority source
        // does not preempt the outstanding request.
        if (irq_ack_i) begin
          state_d  = CLEAR;
          ack_id_d = irq_ack_id_i;
        end else if (!m_ie_i) begin
          state_d = IDLE;
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latched ids. Reset drops the request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      ack_id_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ack_id_q <= ack_id_d;
    end
  end

  assign irq_req_ctrl_o = (state_q == REQ);
  assign irq_id_ctrl_o  = id_q;
  assign irq_o          = |eligible;
  assign irq_pending_o  = pending_q;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Directed testbench for ibex_irq_arbiter. Line 5 is edge-triggered and all
// other lines are level-triggered. Inputs are driven and outputs sampled on the
// falling clock edge. The mask scenario runs only when IBEX_IRQ_MASK_EN is defined.
module tb_ibex_irq_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] lines;
  logic        m_ie;
  logic        ack;
  logic [4:0]  ack_id;
`ifdef IBEX_IRQ_MASK_EN
  logic [15:0] mask;
`endif
  logic        req;
  logic [4:0]  id;
  logic        irq;
  logic [15:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  ibex_irq_arbiter #(
    .NUM_IRQ    (16),
    .SYNC_STAGES(2),
    .EDGE_MASK  (32'h0000_0020)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_lines_i   (lines),
    .m_ie_i        (m_ie),
    .irq_ack_i     (ack),
    .irq_ack_id_i  (ack_id),
`ifdef IBEX_IRQ_MASK_EN
    .irq_mask_i    (mask),
`endif
    .irq_req_ctrl_o(req),
    .irq_id_ctrl_o (id),
    .irq_o         (irq),
    .irq_pending_o (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle ack pulse in REQ. This returns at IDLE with the clear applied.
  task automatic ack_irq(input logic [4:0] aid);
    ack    = 1'b1;
    ack_id = aid;
    step(1);
    ack    = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lines = '0;
    m_ie  = 1'b0;
    ack   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    // 1: reset with all lines high, then release; then an async reset mid-request
    rst_n  = 1'b0;
    lines  = 16'hFFFF;
    m_ie   = 1'b1;
    ack    = 1'b0;
    ack_id = '0;
`ifdef IBEX_IRQ_MASK_EN
    mask   = 16'hFFFF;
`endif
    step(3);
    check("rst_req", req, 0);
    check("rst_id", id, 0);
    check("rst_irq_o", irq, 0);
    check("rst_pending", pending, 0);
    rst_n = 1'b1;
    step(2);
    check("rel_pending_c2", pending, 0);
    step(1);
    check("rel_pending_c3", pending, 32'hFFFF);
    check("rel_req_c3", req, 0);
    check("rel_irq_o_c3", irq, 1);
    step(1);
    check("rel_req_c4", req, 1);
    check("rel_id_c4", id, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_pending", pending, 0);
    do_reset();

    // 2: priority between level lines 3 and 7
    lines = 16'h0088;
    m_ie  = 1'b1;
    step(3);
    check("prio_pending", pending, 32'h0088);
    check("prio_req_early", req, 0);
    step(1);
    check("prio_req", req, 1);
    check("prio_id3", id, 3);
    lines = 16'h0080;
    step(3);
    check("prio_id3_held", id, 3);
    ack_irq(5'd3);
    check("prio_pending_after_ack", pending, 32'h0080);
    check("prio_req_gap", req, 0);
    step(1);
    check("prio_req7", req, 1);
    check("prio_id7", id, 7);
    lines = '0;
    step(3);
    ack_irq(5'd7);
    check("prio_pending_clear", pending, 0);
    step(2);
    check("prio_idle", req, 0);

    // 3: edge-triggered line 5, one-cycle pulse
    m_ie  = 1'b0;
    lines = 16'h0020;
    step(1);
    lines = '0;
    step(1);
    check("edge_pending_early", pending, 0);
    step(1);
    check("edge_pending", pending, 32'h0020);
    step(3);
    check("edge_pending_sticky", pending, 32'h0020);
    check("edge_irq_o", irq, 1);
    check("edge_req_mie0", req, 0);
    m_ie = 1'b1;
    step(1);
    check("edge_req", req, 1);
    check("edge_id", id, 5);
    ack_irq(5'd5);
    check("edge_pending_clear", pending, 0);
    step(3);
    check("edge_no_rereq", req, 0);

    // 4: outstanding request is not preempted by a higher-priority source
    lines = 16'h0010;
    step(4);
    check("frz_req", req, 1);
    check("frz_id4", id, 4);
    lines = 16'h0012;
    step(4);
    check("frz_pending", pending, 32'h0012);
    check("frz_id_still4", id, 4);
    check("frz_req_still", req, 1);
    lines = 16'h0002;
    step(3);
    ack_irq(5'd4);
    check("frz_pending_after_ack", pending, 32'h0002);
    step(1);
    check("frz_id1", id, 1);
    check("frz_req1", req, 1);
    lines = '0;
    step(3);
    ack_irq(5'd1);
    check("frz_pending_clear", pending, 0);

    // 5: global enable, withdrawal, ignored acks
    m_ie  = 1'b0;
    lines = 16'h0004;
    step(3);
    check("en_pending", pending, 32'h0004);
    check("en_irq_o", irq, 1);
    lines = '0;
    step(2);
    check("en_req_mie0", req, 0);
    m_ie = 1'b1;
    step(1);
    check("en_req", req, 1);
    check("en_id", id, 2);
    m_ie = 1'b0;
    step(1);
    check("en_withdraw_req", req, 0);
    check("en_withdraw_id_hold", id, 2);
    check("en_withdraw_pending", pending, 32'h0004);
    ack_irq(5'd2);
    check("en_ack_idle_ignored", pending, 32'h0004);
    m_ie = 1'b1;
    step(1);
    check("en_req_again", req, 1);
    ack_irq(5'd20);
    check("en_ack_oor_ignored", pending, 32'h0004);
    step(1);
    check("en_rereq", req, 1);
    check("en_rereq_id", id, 2);
    ack_irq(5'd2);
    check("en_pending_clear", pending, 0);
    step(2);
    check("en_idle", req, 0);

`ifdef IBEX_IRQ_MASK_EN
    // 6: mask gates eligibility and irq_o but not latching
    mask  = 16'hFFBF;
    lines = 16'h0040;
    step(4);
    check("msk_pending", pending, 32'h0040);
    check("msk_irq_o", irq, 0);
    check("msk_req", req, 0);
    mask = 16'hFFFF;
    #1;
    check("msk_irq_o_on", irq, 1);
    step(1);
    check("msk_req_on", req, 1);
    check("msk_id", id, 6);
    mask  = 16'hFFBF;
    lines = '0;
    step(1);
    check("msk_drop_keeps_req", req, 1);
    mask = 16'hFFFF;
    step(2);
    ack_irq(5'd6);
    check("msk_pending_clear", pending, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
